imm_ctrl_sequencer: RTL and testbench
=====================================

Name: imm_ctrl_sequencer

Overview:
- Hardwired control FSM that fetches and executes I-format ALU instructions (addi, andi, ori) on the bus-based Datapath.
- Drives the Datapath control strobes that benches currently hand-sequence through T0..T5.
- Adds a memory-ready handshake with timeout, single-step/continuous run modes, halt-at-boundary and illegal-opcode trapping.
- Sits between the future top-level CPU wrapper and Datapath; takes IR bits back from Datapath.

Parameters:
- IR_W, 32, instruction width; opcode = ir[IR_W-1 -: OPC_W]
- OPC_W, 5, opcode field width
- ALU_CTRL_W, 5, width of alu_control
- MEM_WAIT_MAX, 15, max cycles T1 waits for mem_ready before timeout (≥1)

Ports:
- clk  in  1  system clock, rising edge
- clr  in  1  reset, asynchronous, active-high
- start  in  1  begin execution from IDLE
- run_mode  in  1  0 = single instruction, 1 = continuous
- halt_req  in  1  stop at next instruction boundary
- mem_ready  in  1  memory read data valid
- ir  in  IR_W  instruction register contents from Datapath
- PCout, Zlowout, MDRout, Rout, Cout  out  1  bus drive strobes
- MARin, PCin, MDRin, IRin, Yin, Zin, Rin  out  1  register load strobes (Zin feeds both Zhighin/Zlowin)
- Gra, Grb  out  1  register-select strobes (Grc tied 0 by wrapper)
- read, memoryRead, pc_increment  out  1  memory/PC controls
- alu_control  out  ALU_CTRL_W  ALU operation
- busy  out  1  high in any state except IDLE/DONE/TRAP
- done  out  1  one-cycle pulse after T5 when stopping
- trap  out  1  sticky error flag
- trap_cause  out  2  00 none, 01 illegal opcode, 10 memory timeout

Behaviour:
- Moore FSM; all control outputs decode from the state register only. clr forces IDLE, wait counter 0, trap 0, trap_cause 00, so every output is 0. Reset mid-instruction aborts immediately and emits no done.
- IDLE: start=1 → T0.
- T0: PCout, MARin, pc_increment, Zin, alu_control=ALU_INC_PC (19). → T1.
- T1: Zlowout, PCin, read, memoryRead, MDRin, pc_increment. PCin is asserted only on the first T1 cycle so PC increments exactly once. If mem_ready=1 → T2. Otherwise increment the wait counter; reaching MEM_WAIT_MAX → TRAP with cause 10.
- T2: MDRout, IRin. → DEC.
- DEC: no strobes. Opcode ADDI (5'b01100), ANDI (5'b01101) or ORI (5'b01110) → T3. Any other opcode → TRAP with cause 01.
- T3: Grb, Rout, Yin. → T4.
- T4: Cout, Zin, alu_control per opcode: ADD=3, AND=1, OR=2; the value is latched in DEC.
- T5: Zlowout, Gra, Rin. → T0 if run_mode=1 and halt_req=0 (sampled in T5). Otherwise → DONE.
- DONE: done=1 for 1 cycle → IDLE. start asserted during DONE is ignored.
- TRAP: busy=0, trap=1, all strobes 0. Only clr exits TRAP.
- halt_req outside T5 is ignored unless still high at T5.
- Latency: start→first T0 = 1 cycle. Instruction length = 7 cycles + extra T1 wait cycles. With mem_ready already high at T1, first done follows start by 8 cycles.
- Wait counter width is clog2(MEM_WAIT_MAX+1). It saturates and clears on leaving T1.

Decomposition:
- Package imm_ctrl_pkg holds:
  - state enum: IDLE, T0, T1, T2, DEC, T3, T4, T5, DONE, TRAP
  - opcode localparams: OPC_ADDI, OPC_ANDI, OPC_ORI
  - ALU codes: ALU_AND=1, ALU_OR=2, ALU_ADD=3, ALU_INC_PC=19
  - trap cause codes
- One sub-module, imm_opc_decode: combinational opcode → {legal, alu_code}.

Test Plan:
- Reset mid-T3 (clr pulse while Grb=1) → all outputs 0 within the same cycle, no done, IDLE after release.
- ir=0x62B7FFF9 (addi R5,R6,-7), start, mem_ready=1 → strobe sequence T0..T5 exactly once each, alu_control 19 in T0 and 3 in T4, done pulse at cycle 8.
- andi (ir=0x6A800095), then ori (ir=0x72B00095) in continuous mode, halt_req raised during the 2nd T3 → alu_control 1 then 2, halt at end of 2nd instruction, exactly one done.
- mem_ready delayed 4 cycles → T1 held 5 cycles, PCin high only in the first, correct completion.
- mem_ready never asserted, MEM_WAIT_MAX=15 → TRAP after 15 T1 cycles, trap_cause=10, start ignored until clr.
- ir opcode 5'b00000 → TRAP from DEC, trap_cause=01, no Rin asserted.

Source files
------------

// File: rtl/imm_ctrl_sequencer_pkg.sv
// Shared types and constants for the I-format ALU control sequencer.
package imm_ctrl_pkg;

    localparam int unsigned OPC_W      = 5;
    localparam int unsigned ALU_CTRL_W = 5;

    typedef enum logic [3:0] {
        IDLE, T0, T1, T2, DEC, T3, T4, T5, DONE, TRAP
    } state_t;

    localparam logic [OPC_W-1:0] OPC_ADDI = 5'b01100;
    localparam logic [OPC_W-1:0] OPC_ANDI = 5'b01101;
    localparam logic [OPC_W-1:0] OPC_ORI  = 5'b01110;

    localparam logic [ALU_CTRL_W-1:0] ALU_AND    = 5'd1;
    localparam logic [ALU_CTRL_W-1:0] ALU_OR     = 5'd2;
    localparam logic [ALU_CTRL_W-1:0] ALU_ADD    = 5'd3;
    localparam logic [ALU_CTRL_W-1:0] ALU_INC_PC = 5'd19;

    localparam logic [1:0] TRAP_NONE    = 2'b00;
    localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
    localparam logic [1:0] TRAP_TIMEOUT = 2'b10;

    // Datapath control strobes, one bit per bus driver / register load
    typedef struct packed {
        logic pc_out;
        logic zlow_out;
        logic mdr_out;
        logic r_out;
        logic c_out;
        logic mar_in;
        logic pc_in;
        logic mdr_in;
        logic ir_in;
        logic y_in;
        logic z_in;
        logic r_in;
        logic gra;
        logic grb;
        logic read;
        logic mem_read;
        logic pc_inc;
    } ctrl_t;

endpackage

// File: rtl/imm_ctrl_sequencer_if.sv
// Sequencer <-> Datapath/CPU-wrapper signal bundle.
interface imm_ctrl_sequencer_if #(
    parameter int unsigned IR_W       = 32,
    parameter int unsigned ALU_CTRL_W = 5
);
    logic                  start;
    logic                  run_mode;
    logic                  halt_req;
    logic                  mem_ready;
    logic [IR_W-1:0]       ir;

    logic PCout, Zlowout, MDRout, Rout, Cout;
    logic MARin, PCin, MDRin, IRin, Yin, Zin, Rin;
    logic Gra, Grb;
    logic read, memoryRead, pc_increment;
    logic [ALU_CTRL_W-1:0] alu_control;
    logic                  busy;
    logic                  done;
    logic                  trap;
    logic [1:0]            trap_cause;

    modport master (
        input  start, run_mode, halt_req, mem_ready, ir,
        output PCout, Zlowout, MDRout, Rout, Cout,
        output MARin, PCin, MDRin, IRin, Yin, Zin, Rin,
        output Gra, Grb, read, memoryRead, pc_increment,
        output alu_control, busy, done, trap, trap_cause
    );

    modport slave (
        output start, run_mode, halt_req, mem_ready, ir,
        input  PCout, Zlowout, MDRout, Rout, Cout,
        input  MARin, PCin, MDRin, IRin, Yin, Zin, Rin,
        input  Gra, Grb, read, memoryRead, pc_increment,
        input  alu_control, busy, done, trap, trap_cause
    );
endinterface

// File: rtl/imm_ctrl_sequencer_opc_decode.sv
// Combinational opcode decode: legality and ALU operation for I-format ops.
module imm_opc_decode
    import imm_ctrl_pkg::*;
#(
    parameter int unsigned OPC_W      = 5,
    parameter int unsigned ALU_CTRL_W = 5
) (
    input  logic [OPC_W-1:0]      opc,
    output logic                  legal_c,
    output logic [ALU_CTRL_W-1:0] alu_code_c
);

    always_comb begin
        legal_c    = 1'b0;
        alu_code_c = '0;
        case (opc)
            OPC_W'(OPC_ADDI): begin legal_c = 1'b1; alu_code_c = ALU_CTRL_W'(ALU_ADD); end
            OPC_W'(OPC_ANDI): begin legal_c = 1'b1; alu_code_c = ALU_CTRL_W'(ALU_AND); end
            OPC_W'(OPC_ORI):  begin legal_c = 1'b1; alu_code_c = ALU_CTRL_W'(ALU_OR);  end
            default: ;
        endcase
    end

endmodule

// File: rtl/imm_ctrl_sequencer.sv
// Hardwired fetch/execute sequencer for addi/andi/ori on the bus Datapath,
// with memory-ready timeout, run modes, boundary halt and trapping.
module imm_ctrl_sequencer
    import imm_ctrl_pkg::*;
#(
    parameter int unsigned IR_W         = 32,
    parameter int unsigned OPC_W        = 5,
    parameter int unsigned ALU_CTRL_W   = 5,
    parameter int unsigned MEM_WAIT_MAX = 15
) (
    input logic                  clk,
    input logic                  clr,
    imm_ctrl_sequencer_if.master bus
);

    localparam int unsigned CNT_W = $clog2(MEM_WAIT_MAX + 1);

    state_t                state_q, state_nxt;
    logic [CNT_W-1:0]      cnt_q, cnt_nxt, cnt_inc;
    logic [ALU_CTRL_W-1:0] alu_op_q, alu_op_nxt;
    logic [1:0]            cause_q, cause_nxt;

    ctrl_t                 ctrl_q, ctrl_nxt;
    logic [ALU_CTRL_W-1:0] alu_out_q, alu_out_nxt;
    logic                  busy_q, busy_nxt;
    logic                  done_q, done_nxt;
    logic                  trap_q, trap_nxt;

    logic                  legal_c;
    logic [ALU_CTRL_W-1:0] alu_code_c;
    logic                  unused_ir;

    assign unused_ir = ^bus.ir[IR_W-OPC_W-1:0];

    imm_opc_decode #(
        .OPC_W      (OPC_W),
        .ALU_CTRL_W (ALU_CTRL_W)
    ) u_decode (
        .opc        (bus.ir[IR_W-1 -: OPC_W]),
        .legal_c    (legal_c),
        .alu_code_c (alu_code_c)
    );

    // State, wait counter, latched ALU op and trap cause
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            alu_op_q <= '0;
            cause_q  <= TRAP_NONE;
        end else begin
            state_q  <= state_nxt;
            cnt_q    <= cnt_nxt;
            alu_op_q <= alu_op_nxt;
            cause_q  <= cause_nxt;
        end
    end

    assign cnt_inc = (cnt_q == CNT_W'(MEM_WAIT_MAX)) ? cnt_q : cnt_q + CNT_W'(1);

    // Next-state and the control word the next state will present
    always_comb begin
        state_nxt   = state_q;
        cnt_nxt     = cnt_q;
        alu_op_nxt  = alu_op_q;
        cause_nxt   = cause_q;
        ctrl_nxt    = '0;
        alu_out_nxt = '0;

        case (state_q)
            IDLE: if (bus.start) state_nxt = T0;
            T0:   state_nxt = T1;
            T1: begin
                if (bus.mem_ready) begin
                    state_nxt = T2;
                    cnt_nxt   = '0;
                end else if (cnt_inc >= CNT_W'(MEM_WAIT_MAX)) begin
                    state_nxt = TRAP;
                    cause_nxt = TRAP_TIMEOUT;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt   = cnt_inc;
                end
            end
            T2:   state_nxt = DEC;
            DEC: begin
                if (legal_c) begin
                    state_nxt  = T3;
                    alu_op_nxt = alu_code_c;
                end else begin
                    state_nxt  = TRAP;
                    cause_nxt  = TRAP_ILLEGAL;
                end
            end
            T3:   state_nxt = T4;
            T4:   state_nxt = T5;
            T5:   state_nxt = (bus.run_mode && !bus.halt_req) ? T0 : DONE;
            DONE: state_nxt = IDLE;
            TRAP: state_nxt = TRAP;
            default: state_nxt = IDLE;
        endcase

        case (state_nxt)
            T0: begin
                ctrl_nxt.pc_out = 1'b1;
                ctrl_nxt.mar_in = 1'b1;
                ctrl_nxt.pc_inc = 1'b1;
                ctrl_nxt.z_in   = 1'b1;
                alu_out_nxt     = ALU_CTRL_W'(ALU_INC_PC);
            end
            T1: begin
                ctrl_nxt.zlow_out = 1'b1;
                ctrl_nxt.pc_in    = (state_q != T1);  // PC loads once despite wait cycles
                ctrl_nxt.read     = 1'b1;
                ctrl_nxt.mem_read = 1'b1;
                ctrl_nxt.mdr_in   = 1'b1;
                ctrl_nxt.pc_inc   = 1'b1;
            end
            T2: begin
                ctrl_nxt.mdr_out = 1'b1;
                ctrl_nxt.ir_in   = 1'b1;
            end
            T3: begin
                ctrl_nxt.grb   = 1'b1;
                ctrl_nxt.r_out = 1'b1;
                ctrl_nxt.y_in  = 1'b1;
            end
            T4: begin
                ctrl_nxt.c_out = 1'b1;
                ctrl_nxt.z_in  = 1'b1;
                alu_out_nxt    = alu_op_nxt;
            end
            T5: begin
                ctrl_nxt.zlow_out = 1'b1;
                ctrl_nxt.gra      = 1'b1;
                ctrl_nxt.r_in     = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy_nxt = !(state_nxt inside {IDLE, DONE, TRAP});
    assign done_nxt = (state_nxt == DONE);
    assign trap_nxt = (state_nxt == TRAP);

    // Output registers track the state register edge-for-edge
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            ctrl_q    <= '0;
            alu_out_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            trap_q    <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_nxt;
            alu_out_q <= alu_out_nxt;
            busy_q    <= busy_nxt;
            done_q    <= done_nxt;
            trap_q    <= trap_nxt;
        end
    end

    assign bus.PCout        = ctrl_q.pc_out;
    assign bus.Zlowout      = ctrl_q.zlow_out;
    assign bus.MDRout       = ctrl_q.mdr_out;
    assign bus.Rout         = ctrl_q.r_out;
    assign bus.Cout         = ctrl_q.c_out;
    assign bus.MARin        = ctrl_q.mar_in;
    assign bus.PCin         = ctrl_q.pc_in;
    assign bus.MDRin        = ctrl_q.mdr_in;
    assign bus.IRin         = ctrl_q.ir_in;
    assign bus.Yin          = ctrl_q.y_in;
    assign bus.Zin          = ctrl_q.z_in;
    assign bus.Rin          = ctrl_q.r_in;
    assign bus.Gra          = ctrl_q.gra;
    assign bus.Grb          = ctrl_q.grb;
    assign bus.read         = ctrl_q.read;
    assign bus.memoryRead   = ctrl_q.mem_read;
    assign bus.pc_increment = ctrl_q.pc_inc;
    assign bus.alu_control  = alu_out_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.trap         = trap_q;
    assign bus.trap_cause   = cause_q;

endmodule

// File: tb/tb_imm_ctrl_sequencer.sv
// Directed bench for imm_ctrl_sequencer: strobe sequences, run modes, waits and traps.
module tb_imm_ctrl_sequencer;

    // Strobe vector order: PCout Zlowout MDRout Rout Cout MARin PCin MDRin IRin
    //                      Yin Zin Rin Gra Grb read memoryRead pc_increment
    localparam logic [16:0] M_T0  = 17'b10000100001000001;
    localparam logic [16:0] M_T1F = 17'b01000011000000111;
    localparam logic [16:0] M_T1  = 17'b01000001000000111;
    localparam logic [16:0] M_T2  = 17'b00100000100000000;
    localparam logic [16:0] M_T3  = 17'b00010000010001000;
    localparam logic [16:0] M_T4  = 17'b00001000001000000;
    localparam logic [16:0] M_T5  = 17'b01000000000110000;
    localparam logic [16:0] M_NO  = 17'b0;

    localparam logic [31:0] IR_ADDI = 32'h62B7FFF9;
    localparam logic [31:0] IR_ANDI = 32'h6A800095;
    localparam logic [31:0] IR_ORI  = 32'h72B00095;

    logic clk = 1'b0;
    logic clr;
    int   checks = 0;
    int   errors = 0;

    imm_ctrl_sequencer_if #(.IR_W(32), .ALU_CTRL_W(5)) bus ();

    imm_ctrl_sequencer #(
        .IR_W(32), .OPC_W(5), .ALU_CTRL_W(5), .MEM_WAIT_MAX(15)
    ) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [16:0] strobes();
        return {bus.PCout, bus.Zlowout, bus.MDRout, bus.Rout, bus.Cout,
                bus.MARin, bus.PCin, bus.MDRin, bus.IRin, bus.Yin, bus.Zin,
                bus.Rin, bus.Gra, bus.Grb, bus.read, bus.memoryRead, bus.pc_increment};
    endfunction

    function automatic logic [26:0] all_outs();
        return {strobes(), bus.alu_control, bus.busy, bus.done, bus.trap, bus.trap_cause};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clr = 1'b1;
        bus.start = 1'b0; bus.run_mode = 1'b0; bus.halt_req = 1'b0;
        bus.mem_ready = 1'b0; bus.ir = '0;
        tick(); tick();
        checks++;
        if (all_outs() !== 27'b0) begin
            errors++; $display("FAIL reset_outputs: got %h expected 0", all_outs());
        end
        clr = 1'b0;
        tick(); tick();
        checks++;
        if (all_outs() !== 27'b0) begin
            errors++; $display("FAIL reset_idle: got %h expected 0", all_outs());
        end
    endtask

    task automatic test_addi();
        logic [16:0] exp_s   [0:8];
        logic [4:0]  exp_alu [0:8];
        logic        exp_b   [0:8];
        exp_s   = '{M_T0, M_T1F, M_T2, M_NO, M_T3, M_T4, M_T5, M_NO, M_NO};
        exp_alu = '{5'd19, 5'd0, 5'd0, 5'd0, 5'd0, 5'd3, 5'd0, 5'd0, 5'd0};
        exp_b   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        bus.ir = IR_ADDI; bus.mem_ready = 1'b1; bus.run_mode = 1'b0;
        bus.start = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            bus.start = 1'b0;
            checks++;
            if (strobes() !== exp_s[i]) begin
                errors++; $display("FAIL addi_strobes cyc%0d: got %b expected %b", i+1, strobes(), exp_s[i]);
            end
            checks++;
            if (bus.alu_control !== exp_alu[i]) begin
                errors++; $display("FAIL addi_alu cyc%0d: got %0d expected %0d", i+1, bus.alu_control, exp_alu[i]);
            end
            checks++;
            if (bus.done !== (i == 7)) begin
                errors++; $display("FAIL addi_done cyc%0d: got %b expected %b", i+1, bus.done, (i == 7));
            end
            checks++;
            if (bus.busy !== exp_b[i]) begin
                errors++; $display("FAIL addi_busy cyc%0d: got %b expected %b", i+1, bus.busy, exp_b[i]);
            end
        end
    endtask

    task automatic test_continuous();
        int          done_cnt = 0;
        logic        done15 = 1'b0;
        logic        busy16 = 1'b1;
        logic [4:0]  alu6 = '0, alu13 = '0;
        logic [16:0] s8 = '0, s14 = '0;
        bus.ir = IR_ANDI; bus.mem_ready = 1'b1; bus.run_mode = 1'b1; bus.halt_req = 1'b0;
        bus.start = 1'b1;
        for (int cyc = 1; cyc <= 17; cyc++) begin
            tick();
            bus.start = 1'b0;
            if (bus.done) done_cnt++;
            if (cyc == 6)  alu6  = bus.alu_control;
            if (cyc == 8)  s8    = strobes();
            if (cyc == 13) alu13 = bus.alu_control;
            if (cyc == 14) s14   = strobes();
            if (cyc == 15) done15 = bus.done;
            if (cyc == 16) busy16 = bus.busy;
            if (cyc == 8)  bus.ir = IR_ORI;
            if (cyc == 12) bus.halt_req = 1'b1;
        end
        bus.halt_req = 1'b0; bus.run_mode = 1'b0;
        checks++;
        if (alu6 !== 5'd1) begin errors++; $display("FAIL cont_andi_alu: got %0d expected 1", alu6); end
        checks++;
        if (alu13 !== 5'd2) begin errors++; $display("FAIL cont_ori_alu: got %0d expected 2", alu13); end
        checks++;
        if (s8 !== M_T0) begin errors++; $display("FAIL cont_refetch: got %b expected %b", s8, M_T0); end
        checks++;
        if (s14 !== M_T5) begin errors++; $display("FAIL cont_t5: got %b expected %b", s14, M_T5); end
        checks++;
        if (done15 !== 1'b1) begin errors++; $display("FAIL cont_done_cycle: got %b expected 1", done15); end
        checks++;
        if (done_cnt != 1) begin errors++; $display("FAIL cont_done_count: got %0d expected 1", done_cnt); end
        checks++;
        if (busy16 !== 1'b0) begin errors++; $display("FAIL cont_stopped: got %b expected 0", busy16); end
    endtask

    task automatic test_mem_wait();
        int   pcin_cnt = 0, t1_cnt = 0;
        logic done12 = 1'b0;
        logic [16:0] s2 = '0, s7 = '0;
        bus.ir = IR_ADDI; bus.mem_ready = 1'b0; bus.run_mode = 1'b0;
        bus.start = 1'b1;
        for (int cyc = 1; cyc <= 14; cyc++) begin
            tick();
            bus.start = 1'b0;
            if (bus.PCin) pcin_cnt++;
            if (bus.memoryRead) t1_cnt++;
            if (cyc == 2)  s2 = strobes();
            if (cyc == 7)  s7 = strobes();
            if (cyc == 12) done12 = bus.done;
            if (cyc == 6)  bus.mem_ready = 1'b1;
        end
        checks++;
        if (t1_cnt != 5) begin errors++; $display("FAIL wait_t1_len: got %0d expected 5", t1_cnt); end
        checks++;
        if (pcin_cnt != 1) begin errors++; $display("FAIL wait_pcin_count: got %0d expected 1", pcin_cnt); end
        checks++;
        if (s2 !== M_T1F) begin errors++; $display("FAIL wait_first_t1: got %b expected %b", s2, M_T1F); end
        checks++;
        if (s7 !== M_T2) begin errors++; $display("FAIL wait_t2: got %b expected %b", s7, M_T2); end
        checks++;
        if (done12 !== 1'b1) begin errors++; $display("FAIL wait_done: got %b expected 1", done12); end
    endtask

    task automatic test_reset_mid();
        int done_cnt = 0;
        bus.ir = IR_ADDI; bus.mem_ready = 1'b1; bus.run_mode = 1'b0;
        bus.start = 1'b1;
        for (int cyc = 1; cyc <= 5; cyc++) begin
            tick();
            bus.start = 1'b0;
        end
        checks++;
        if (bus.Grb !== 1'b1) begin errors++; $display("FAIL mid_in_t3: got Grb=%b expected 1", bus.Grb); end
        clr = 1'b1;
        #1;
        checks++;
        if (all_outs() !== 27'b0) begin
            errors++; $display("FAIL mid_async_clear: got %h expected 0", all_outs());
        end
        tick();
        clr = 1'b0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            tick();
            if (bus.done) done_cnt++;
        end
        checks++;
        if (done_cnt != 0) begin errors++; $display("FAIL mid_no_done: got %0d expected 0", done_cnt); end
        checks++;
        if (all_outs() !== 27'b0) begin errors++; $display("FAIL mid_idle: got %h expected 0", all_outs()); end
    endtask

    task automatic test_timeout();
        int t1_cnt = 0;
        bus.ir = IR_ADDI; bus.mem_ready = 1'b0; bus.run_mode = 1'b0;
        bus.start = 1'b1;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            tick();
            bus.start = 1'b0;
            if (bus.memoryRead) t1_cnt++;
        end
        checks++;
        if (t1_cnt != 15) begin errors++; $display("FAIL timeout_t1_len: got %0d expected 15", t1_cnt); end
        checks++;
        if ({bus.trap, bus.trap_cause, bus.busy} !== 4'b1100) begin
            errors++; $display("FAIL timeout_trap: got trap/cause/busy %b expected 1100", {bus.trap, bus.trap_cause, bus.busy});
        end
        bus.start = 1'b1;
        for (int cyc = 0; cyc < 5; cyc++) tick();
        bus.start = 1'b0;
        checks++;
        if ({strobes(), bus.trap, bus.trap_cause} !== {M_NO, 1'b1, 2'b10}) begin
            errors++; $display("FAIL timeout_start_ignored: got %b expected %b", {strobes(), bus.trap, bus.trap_cause}, {M_NO, 1'b1, 2'b10});
        end
        clr = 1'b1; tick(); clr = 1'b0; tick();
        checks++;
        if ({bus.trap, bus.trap_cause} !== 3'b000) begin
            errors++; $display("FAIL timeout_clr: got %b expected 000", {bus.trap, bus.trap_cause});
        end
    endtask

    task automatic test_illegal();
        int   rin_cnt = 0;
        logic trap4 = 1'b1, trap5 = 1'b0;
        logic [1:0] cause5 = '0;
        bus.ir = 32'h0000_1234; bus.mem_ready = 1'b1; bus.run_mode = 1'b0;
        bus.start = 1'b1;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            tick();
            bus.start = 1'b0;
            if (bus.Rin) rin_cnt++;
            if (cyc == 4) trap4 = bus.trap;
            if (cyc == 5) begin trap5 = bus.trap; cause5 = bus.trap_cause; end
        end
        checks++;
        if (trap4 !== 1'b0) begin errors++; $display("FAIL illegal_dec_no_trap: got %b expected 0", trap4); end
        checks++;
        if (trap5 !== 1'b1) begin errors++; $display("FAIL illegal_trap: got %b expected 1", trap5); end
        checks++;
        if (cause5 !== 2'b01) begin errors++; $display("FAIL illegal_cause: got %b expected 01", cause5); end
        checks++;
        if (rin_cnt != 0) begin errors++; $display("FAIL illegal_no_rin: got %0d expected 0", rin_cnt); end
        clr = 1'b1; tick(); clr = 1'b0; tick();
    endtask

    initial begin
        test_reset();
        test_addi();
        test_continuous();
        test_mem_wait();
        test_reset_mid();
        test_timeout();
        test_illegal();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
